// File: rtl/spraid_spi_lane.sv
// SPI master lane (mode 0, MSB first) fed by a small TX byte FIFO.
// Consecutive queued bytes are shifted back-to-back inside a single chip-select window.
module spraid_spi_lane #(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       cs_hold,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       spi_clk,
    output logic       spi_cs,
    output logic       spi_mosi,
    input  logic       spi_miso
);

    generate
        if (CLK_DIV < 1) begin : g_bad_clk_div
            $error("spraid_spi_lane: CLK_DIV must be at least 1");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
            $error("spraid_spi_lane: FIFO_DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        HOLD,
        TRAIL
    } state_t;

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [6:0]       tx_shift;
    logic [7:0]       rx_shift;
    logic [7:0]       head;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             div_done;
    logic             byte_end;

    assign fifo_empty = (count == '0);
    assign tx_ready   = (count != FIFO_FULL);
    assign push       = tx_valid && tx_ready;
    assign head       = mem[rd_ptr];
    assign div_done   = (div_cnt == DIV_LAST);
    // The last half-period of a byte ends on the 8th falling spi_clk edge.
    assign byte_end   = (state == SHIFT) && div_done && spi_clk && (bit_cnt == 3'd7);
    assign pop        = !fifo_empty && ((state == IDLE) || (state == HOLD) || byte_end);
    assign busy       = (state != IDLE) || !fifo_empty;

    always_ff @(posedge wb_clk_i) begin
        if (push && !wb_rst_i) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            spi_cs   <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    spi_cs   <= 1'b1;
                    spi_clk  <= 1'b0;
                    spi_mosi <= 1'b0;
                    div_cnt  <= '0;
                    bit_cnt  <= '0;
                    if (!fifo_empty) begin
                        tx_shift <= head[6:0];
                        spi_mosi <= head[7];
                        spi_cs   <= 1'b0;
                        state    <= LEAD;
                    end
                end
                LEAD: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                SHIFT: begin
                    if (!div_done) begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end else begin
                        div_cnt <= '0;
                        spi_clk <= ~spi_clk;
                        if (!spi_clk) begin
                            rx_shift <= {rx_shift[6:0], spi_miso};
                        end else if (bit_cnt != 3'd7) begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            spi_mosi <= tx_shift[6];
                            tx_shift <= {tx_shift[5:0], 1'b0};
                        end else begin
                            // Byte complete: cs_hold is only consulted here.
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                            if (!fifo_empty) begin
                                tx_shift <= head[6:0];
                                spi_mosi <= head[7];
                            end else if (cs_hold) begin
                                spi_mosi <= 1'b0;
                                state    <= HOLD;
                            end else begin
                                spi_mosi <= 1'b0;
                                state    <= TRAIL;
                            end
                        end
                    end
                end
                HOLD: begin
                    spi_cs  <= 1'b0;
                    spi_clk <= 1'b0;
                    div_cnt <= '0;
                    if (!fifo_empty) begin
                        tx_shift <= head[6:0];
                        spi_mosi <= head[7];
                        state    <= LEAD;
                    end else if (!cs_hold) begin
                        state <= TRAIL;
                    end
                end
                TRAIL: begin
                    spi_clk <= 1'b0;
                    if (div_done) begin
                        div_cnt <= '0;
                        spi_cs  <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + DIV_ONE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    spi_cs <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spraid_spi_lane.sv
// Directed bench for spraid_spi_lane (CLK_DIV=2, FIFO_DEPTH=4) with hand-computed expectations.
module tb_spraid_spi_lane;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       cs_hold  = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       spi_clk;
    logic       spi_cs;
    logic       spi_mosi;
    logic       spi_miso;
    logic       loop_en  = 1'b1;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_push_cyc = 0;

    // Activity recorded by the monitor; tests work on deltas from a snapshot.
    logic       mosi_log    [256];
    int         rise_cyc_log[256];
    logic [7:0] rx_log      [64];
    int         rxv_cyc_log [64];
    int rise_total   = 0;
    int cs_low_total = 0;
    int cs_fall_total = 0;
    int cs_fall_cyc  = 0;
    int cs_rise_cyc  = 0;
    int rxv_total    = 0;
    int rxv_long     = 0;
    logic prev_clk = 1'b0;
    logic prev_cs  = 1'b1;
    logic prev_rxv = 1'b0;

    assign spi_miso = loop_en ? spi_mosi : 1'b0;

    spraid_spi_lane #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .cs_hold  (cs_hold),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .spi_clk  (spi_clk),
        .spi_cs   (spi_cs),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) cyc <= cyc + 1;

    always @(negedge wb_clk_i) begin
        if (spi_clk && !prev_clk) begin
            mosi_log[rise_total & 255]     = spi_mosi;
            rise_cyc_log[rise_total & 255] = cyc;
            rise_total++;
        end
        if (!spi_cs) cs_low_total++;
        if (!spi_cs && prev_cs) begin
            cs_fall_total++;
            cs_fall_cyc = cyc;
        end
        if (spi_cs && !prev_cs) cs_rise_cyc = cyc;
        if (rx_valid) begin
            rx_log[rxv_total & 63]      = rx_data;
            rxv_cyc_log[rxv_total & 63] = cyc;
            rxv_total++;
            if (prev_rxv) rxv_long++;
        end
        prev_clk = spi_clk;
        prev_cs  = spi_cs;
        prev_rxv = rx_valid;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called on a falling clock edge; the push lands on the following rising edge.
    task automatic applyStimulus(input logic [7:0] b);
        int waited = 0;
        while (!tx_ready && waited < 300) begin
            @(negedge wb_clk_i);
            waited++;
        end
        if (!tx_ready) checkOutput("push_ready_wait", 64'(tx_ready), 64'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge wb_clk_i);
        tx_valid = 1'b0;
        last_push_cyc = cyc;
    endtask

    task automatic waitIdle(input string tag, input int bound);
        int n = 0;
        @(negedge wb_clk_i);
        while (busy && n < bound) begin
            @(negedge wb_clk_i);
            n++;
        end
        repeat (3) @(negedge wb_clk_i);
        checkOutput(tag, 64'(busy), 64'd0);
    endtask

    function automatic logic [63:0] mosiBits(input int base, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[62:0], mosi_log[(base + i) & 255]};
        return v;
    endfunction

    function automatic logic [63:0] rxBytes(input int base, input int n);
        logic [63:0] v = '0;
        for (int i = 0; i < n; i++) v = {v[55:0], rx_log[(base + i) & 63]};
        return v;
    endfunction

    initial begin
        int b_rise, b_rxv, b_fall, b_low;
        int p_first, mx, mn, d, seen, n;
        logic pclk;

        // Reset with a push request held high: nothing may be queued.
        tx_valid = 1'b1;
        tx_data  = 8'hEE;
        repeat (3) @(negedge wb_clk_i);
        checkOutput("rst_cs",       64'(spi_cs),   64'd1);
        checkOutput("rst_clk",      64'(spi_clk),  64'd0);
        checkOutput("rst_mosi",     64'(spi_mosi), 64'd0);
        checkOutput("rst_rx_data",  64'(rx_data),  64'h00);
        checkOutput("rst_rx_valid", 64'(rx_valid), 64'd0);
        checkOutput("rst_busy",     64'(busy),     64'd0);
        checkOutput("rst_tx_ready", 64'(tx_ready), 64'd1);
        wb_rst_i = 1'b0;
        tx_valid = 1'b0;
        repeat (5) @(negedge wb_clk_i);
        checkOutput("rst_push_ignored_busy", 64'(busy),   64'd0);
        checkOutput("rst_push_ignored_cs",   64'(spi_cs), 64'd1);

        // Single byte in loopback.
        $display("[TB] single byte 0xA5 loopback");
        b_rise = rise_total; b_rxv = rxv_total; b_fall = cs_fall_total; b_low = cs_low_total;
        applyStimulus(8'hA5);
        waitIdle("t1_idle", 200);
        checkOutput("t1_cs_low_cycles", 64'(cs_low_total - b_low),  64'd36);
        checkOutput("t1_cs_windows",    64'(cs_fall_total - b_fall), 64'd1);
        checkOutput("t1_clk_pulses",    64'(rise_total - b_rise),   64'd8);
        checkOutput("t1_cs_latency",    64'(cs_fall_cyc - last_push_cyc), 64'd1);
        checkOutput("t1_first_rise",    64'(rise_cyc_log[b_rise & 255] - cs_fall_cyc), 64'd4);
        checkOutput("t1_mosi_bits",     mosiBits(b_rise, 8), 64'hA5);
        checkOutput("t1_rx_pulses",     64'(rxv_total - b_rxv), 64'd1);
        checkOutput("t1_rx_byte",       rxBytes(b_rxv, 1), 64'hA5);
        checkOutput("t1_rx_data_held",  64'(rx_data), 64'hA5);

        // Three bytes back-to-back with MISO tied low.
        $display("[TB] back-to-back 0x01 0x80 0xFF, miso low");
        loop_en = 1'b0;
        b_rise = rise_total; b_rxv = rxv_total; b_fall = cs_fall_total; b_low = cs_low_total;
        applyStimulus(8'h01);
        applyStimulus(8'h80);
        applyStimulus(8'hFF);
        waitIdle("t2_idle", 400);
        checkOutput("t2_cs_windows",    64'(cs_fall_total - b_fall), 64'd1);
        checkOutput("t2_cs_low_cycles", 64'(cs_low_total - b_low),  64'd100);
        checkOutput("t2_clk_pulses",    64'(rise_total - b_rise),   64'd24);
        checkOutput("t2_mosi_bits",     mosiBits(b_rise, 24), 64'h0180FF);
        checkOutput("t2_rx_pulses",     64'(rxv_total - b_rxv), 64'd3);
        checkOutput("t2_rx_bytes",      rxBytes(b_rxv, 3), 64'h000000);
        mx = 0; mn = 1000;
        for (int i = 1; i < 24; i++) begin
            d = rise_cyc_log[(b_rise + i) & 255] - rise_cyc_log[(b_rise + i - 1) & 255];
            if (d > mx) mx = d;
            if (d < mn) mn = d;
        end
        checkOutput("t2_max_rise_gap", 64'(mx), 64'd4);
        checkOutput("t2_min_rise_gap", 64'(mn), 64'd4);
        loop_en = 1'b1;

        // Fill the FIFO, then one more push that must wait for tx_ready.
        $display("[TB] fill FIFO and stall on tx_ready");
        b_rise = rise_total; b_rxv = rxv_total; b_fall = cs_fall_total;
        applyStimulus(8'h11);
        applyStimulus(8'h22);
        applyStimulus(8'h33);
        applyStimulus(8'h44);
        applyStimulus(8'h55);
        checkOutput("t3_ready_low_when_full", 64'(tx_ready), 64'd0);
        applyStimulus(8'h66);
        waitIdle("t3_idle", 800);
        checkOutput("t3_rx_pulses",  64'(rxv_total - b_rxv), 64'd6);
        checkOutput("t3_rx_order",   rxBytes(b_rxv, 6), 64'h112233445566);
        checkOutput("t3_clk_pulses", 64'(rise_total - b_rise), 64'd48);
        checkOutput("t3_cs_windows", 64'(cs_fall_total - b_fall), 64'd1);

        // cs_hold keeps the window open between two separated bytes.
        $display("[TB] cs_hold across a 50-cycle gap");
        b_rise = rise_total; b_rxv = rxv_total; b_fall = cs_fall_total;
        cs_hold = 1'b1;
        applyStimulus(8'h3C);
        repeat (50) @(negedge wb_clk_i);
        checkOutput("t4_hold_cs",        64'(spi_cs), 64'd0);
        checkOutput("t4_hold_busy",      64'(busy),   64'd1);
        checkOutput("t4_hold_rx_pulses", 64'(rxv_total - b_rxv), 64'd1);
        applyStimulus(8'hC3);
        p_first = last_push_cyc;
        cs_hold = 1'b0;
        waitIdle("t4_idle", 200);
        checkOutput("t4_cs_windows",  64'(cs_fall_total - b_fall), 64'd1);
        checkOutput("t4_clk_pulses",  64'(rise_total - b_rise), 64'd16);
        checkOutput("t4_rx_bytes",    rxBytes(b_rxv, 2), 64'h3CC3);
        checkOutput("t4_lead_after_hold", 64'(rise_cyc_log[(b_rise + 8) & 255] - p_first), 64'd5);
        checkOutput("t4_trail_len",   64'(cs_rise_cyc - rise_cyc_log[(b_rise + 15) & 255]), 64'd4);
        checkOutput("t4_cs_released", 64'(spi_cs), 64'd1);

        // Reset at the 3rd rising spi_clk with two bytes still queued.
        $display("[TB] reset in mid-byte");
        b_rise = rise_total; b_rxv = rxv_total;
        applyStimulus(8'h5A);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        seen = 0; n = 0; pclk = spi_clk;
        while (seen < 3 && n < 200) begin
            @(negedge wb_clk_i);
            if (spi_clk && !pclk) seen++;
            pclk = spi_clk;
            n++;
        end
        checkOutput("t5_reached_third_rise", 64'(seen), 64'd3);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        checkOutput("t5_cs",       64'(spi_cs),   64'd1);
        checkOutput("t5_clk",      64'(spi_clk),  64'd0);
        checkOutput("t5_busy",     64'(busy),     64'd0);
        checkOutput("t5_tx_ready", 64'(tx_ready), 64'd1);
        wb_rst_i = 1'b0;
        repeat (60) @(negedge wb_clk_i);
        checkOutput("t5_no_rx_pulse",   64'(rxv_total - b_rxv), 64'd0);
        checkOutput("t5_no_more_clks",  64'(rise_total - b_rise), 64'd3);
        checkOutput("t5_queue_dropped", 64'(busy), 64'd0);

        // Push lands on the same edge as the end-of-byte pop with 3 queued.
        $display("[TB] simultaneous push and pop");
        b_rxv = rxv_total;
        applyStimulus(8'hA1);
        applyStimulus(8'hB2);
        applyStimulus(8'hC3);
        applyStimulus(8'hD4);
        repeat (31) @(negedge wb_clk_i);
        applyStimulus(8'hE5);
        p_first = last_push_cyc;
        checkOutput("t6_ready_after_swap", 64'(tx_ready), 64'd1);
        applyStimulus(8'hF6);
        checkOutput("t6_ready_low_at_four", 64'(tx_ready), 64'd0);
        waitIdle("t6_idle", 800);
        checkOutput("t6_push_on_byte_end", 64'(rxv_cyc_log[b_rxv & 63] - p_first), 64'd0);
        checkOutput("t6_rx_order", rxBytes(b_rxv, 6), 64'hA1B2C3D4E5F6);

        checkOutput("rx_valid_single_cycle", 64'(rxv_long), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
